spike_event_logger: RTL and testbench

Downstream consumer of the neuron network's 3-bit spike output vector. Detects rising edges on each spike line and time-stamps them with a free-running prescaled tick counter. Pushes each event word into a small synchronous FIFO. The FIFO is drained through a simple read-request port that the SPI slave's read path will serve on miso.

---
 rtl/snn_pkg.sv | 28 ++
 rtl/spike_event_logger_if.sv | 61 ++++++
 rtl/snn_sync_fifo.sv | 83 ++++++++
 rtl/spike_event_logger.sv | 108 ++++++++++
 tb/tb_spike_event_logger.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spike network's logging path.
//   NUM_SPIKES_DEF / TS_WIDTH_DEF : default spike-vector and timestamp widths
//   EVT_WIDTH                     : width of one logged event word
//   FIFO_DEPTH_DEF / PRESCALE_DEF : default event storage depth and tick rate
//   event_t                       : event word layout, edges in the MSBs
//   cnt_width()                   : occupancy counter width for a FIFO depth
// ---------------------------------------------------------------------------
package snn_pkg;

  localparam int NUM_SPIKES_DEF = 3;
  localparam int TS_WIDTH_DEF   = 5;
  localparam int EVT_WIDTH      = NUM_SPIKES_DEF + TS_WIDTH_DEF;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PRESCALE_DEF   = 16;

  typedef struct packed {
    logic [NUM_SPIKES_DEF-1:0] edges;
    logic [TS_WIDTH_DEF-1:0]   ts;
  } event_t;

  // An occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spike_event_logger_if.sv
// ---------------------------------------------------------------------------
// spike_event_logger_if
// Read-side port of the spike event logger, as seen by the SPI read path.
//   rd_req         : pop request, one word per asserted cycle
//   clear_overflow : clears the sticky overflow flag
//   rd_data        : popped event word {edges, timestamp}
//   rd_valid       : one-cycle pulse, rd_data valid
//   empty/full     : occupancy flags
//   count          : occupancy, 0..FIFO_DEPTH
//   overflow       : sticky, at least one event was dropped
//
// Handshake: a request/response pair with no back-pressure. A rd_req seen
// in cycle N while the logger is non-empty is always accepted and answered
// by rd_valid=1 with rd_data in cycle N+1. A rd_req while empty is simply
// ignored (no rd_valid). rd_data holds its last value between pulses.
//
// Modports: master = the reader, slave = the logger.
// ---------------------------------------------------------------------------
interface spike_event_logger_if
  import snn_pkg::*;
#(
  parameter int NUM_SPIKES = NUM_SPIKES_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

  localparam int EVT_W = NUM_SPIKES + TS_WIDTH;
  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic             rd_req;
  logic             clear_overflow;
  logic [EVT_W-1:0] rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output rd_req,
    output clear_overflow,
    input  rd_data,
    input  rd_valid,
    input  empty,
    input  full,
    input  count,
    input  overflow
  );

  modport slave (
    input  rd_req,
    input  clear_overflow,
    output rd_data,
    output rd_valid,
    output empty,
    output full,
    output count,
    output overflow
  );

endinterface

// File: rtl/snn_sync_fifo.sv
// ---------------------------------------------------------------------------
// snn_sync_fifo
// Single-clock FIFO with a registered read port (1-cycle pop latency).
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request and data
//   pop        : read request; ignored while empty
//   rdata      : last popped word, held between pops
//   rvalid     : one-cycle pulse, rdata was updated by a pop
//   count      : occupancy 0..DEPTH
//   full/empty : derived from count
// A push while full is accepted only if a pop is accepted in the same cycle.
// There is no fall-through: a word pushed in cycle N can be popped from N+1.
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module snn_sync_fifo
  import snn_pkg::*;
#(
  parameter int WIDTH = EVT_WIDTH,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic                        rvalid,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Empty: the pop is dropped, never the push. Full: the push rides on a
  // concurrent pop, so occupancy cannot exceed DEPTH.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // When full with push and pop together, wr_ptr == rd_ptr: the read
  // samples the old (oldest) word before the write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_logger.sv
// ---------------------------------------------------------------------------
// spike_event_logger
// Time-stamps rising edges on the neuron network's spike outputs and queues
// them for readout over the SPI read path.
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   enable  : tick counter runs and events are captured while high
//   spikes  : spike vector, clk-synchronous
//   rd_if   : read port (slave side), see spike_event_logger_if
// Event word = {edges, timestamp}; edges in the MSBs. The timestamp is a
// TS_WIDTH-bit counter advanced once every PRESCALE enabled cycles and
// wrapping silently.
// ---------------------------------------------------------------------------
module spike_event_logger
  import snn_pkg::*;
#(
  parameter int NUM_SPIKES = NUM_SPIKES_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PRESCALE   = PRESCALE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_SPIKES-1:0] spikes,
  spike_event_logger_if.slave   rd_if
);

  localparam int EVT_W = NUM_SPIKES + TS_WIDTH;
  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSC_W-1:0]      psc;
  logic                  psc_wrap;
  logic [TS_WIDTH-1:0]   ts;
  logic [NUM_SPIKES-1:0] spikes_d;
  logic [NUM_SPIKES-1:0] edges;
  logic                  push;
  logic                  drop;
  logic                  fifo_full;
  logic                  overflow_q;

  // Prescaler and timestamp. Both freeze while enable is low. A push in
  // the same cycle as a tick stores the pre-increment timestamp, which
  // falls out of sampling ts combinationally below.
  assign psc_wrap = (psc == PSC_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc <= '0;
      ts  <= '0;
    end else if (enable) begin
      if (psc_wrap) begin
        psc <= '0;
        ts  <= ts + 1'b1;
      end else begin
        psc <= psc + 1'b1;
      end
    end
  end

  // The previous-cycle sample is kept even while disabled, so a line that
  // rose while disabled does not produce a late event on re-enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spikes_d <= '0;
    end else begin
      spikes_d <= spikes;
    end
  end

  assign edges = spikes & ~spikes_d;
  assign push  = enable && (|edges);

  // A word is lost only when full and no pop frees a slot this cycle;
  // full implies non-empty, so rd_req alone decides whether the pop happens.
  assign drop = push && fifo_full && !rd_if.rd_req;

  // Setting wins over clearing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (rd_if.clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign rd_if.overflow = overflow_q;
  assign rd_if.full     = fifo_full;

  snn_sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push   (push),
    .wdata  ({edges, ts}),
    .pop    (rd_if.rd_req),
    .rdata  (rd_if.rd_data),
    .rvalid (rd_if.rd_valid),
    .count  (rd_if.count),
    .full   (fifo_full),
    .empty  (rd_if.empty)
  );

endmodule

// File: tb/tb_spike_event_logger.sv
// ---------------------------------------------------------------------------
// tb_spike_event_logger
// Directed scenarios followed by randomized traffic, each cycle compared
// against a queue-based reference model of the logger.
// ---------------------------------------------------------------------------
module tb_spike_event_logger;
  import snn_pkg::*;

  localparam int NS  = 3;
  localparam int TSW = 5;
  localparam int D   = 8;
  localparam int P   = 16;
  localparam int EW  = NS + TSW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NS-1:0] spikes;

  always #5 clk = ~clk;

  spike_event_logger_if #(.NUM_SPIKES(NS), .TS_WIDTH(TSW), .FIFO_DEPTH(D)) rif ();

  spike_event_logger #(
    .NUM_SPIKES (NS),
    .TS_WIDTH   (TSW),
    .FIFO_DEPTH (D),
    .PRESCALE   (P)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .spikes (spikes),
    .rd_if  (rif.slave)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0] exp_q[$];
  int            en_cycles;
  logic [NS-1:0] m_prev;
  logic          m_ovf;
  logic [EW-1:0] m_rd_data;
  logic          m_rd_valid;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    en_cycles  = 0;
    m_prev     = '0;
    m_ovf      = 1'b0;
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
  endtask

  // One clock of logger behaviour: timestamp is the number of whole
  // PRESCALE periods of enabled time since reset, modulo 2^TSW.
  task automatic model_cycle(input logic en, input logic [NS-1:0] sp,
                             input logic rq, input logic clr);
    logic [NS-1:0] e;
    int            size0;
    logic          pop;
    logic          drop;
    event_t        w;
    logic [EW-1:0] wv;
    e       = sp & ~m_prev;
    m_prev  = sp;
    size0   = exp_q.size();
    pop     = rq && (size0 > 0);
    drop    = 1'b0;
    w.edges = e;
    w.ts    = TSW'((en_cycles / P) % (1 << TSW));
    wv      = w;
    m_rd_valid = pop;
    if (pop) m_rd_data = exp_q.pop_front();
    if (en && (e != '0)) begin
      if (size0 < D || pop) exp_q.push_back(wv);
      else drop = 1'b1;
    end
    if (clr)  m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    if (en)   en_cycles++;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rd_valid"}, 32'(rif.rd_valid), 32'(m_rd_valid));
    check({tag, ".rd_data"},  32'(rif.rd_data),  32'(m_rd_data));
    check({tag, ".count"},    32'(rif.count),    exp_q.size());
    check({tag, ".empty"},    32'(rif.empty),    32'(exp_q.size() == 0));
    check({tag, ".full"},     32'(rif.full),     32'(exp_q.size() == D));
    check({tag, ".overflow"}, 32'(rif.overflow), 32'(m_ovf));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic [NS-1:0] sp, input logic rq,
                      input logic clr, input string tag);
    @(negedge clk);
    enable             = en;
    spikes             = sp;
    rif.rd_req         = rq;
    rif.clear_overflow = clr;
    model_cycle(en, sp, rq, clr);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".rd_data"},  32'(rif.rd_data),  0);
    check({tag, ".rd_valid"}, 32'(rif.rd_valid), 0);
    check({tag, ".empty"},    32'(rif.empty),    1);
    check({tag, ".full"},     32'(rif.full),     0);
    check({tag, ".count"},    32'(rif.count),    0);
    check({tag, ".overflow"}, 32'(rif.overflow), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int saved;
    reset              = 1'b0;
    enable             = 1'b1;
    spikes             = 3'b111;
    rif.rd_req         = 1'b0;
    rif.clear_overflow = 1'b0;
    model_reset();

    // Reset held for 3 cycles with all spike lines high.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    enable = 1'b0;
    spikes = '0;
    reset  = 1'b1;
    step(1'b0, 3'b000, 1'b0, 1'b0, "post_reset");
    check("post_reset.count", 32'(rif.count), 0);

    // Single event at enabled cycle 40 -> timestamp 2.
    repeat (40) step(1'b1, 3'b000, 1'b0, 1'b0, "idle");
    step(1'b1, 3'b010, 1'b0, 1'b0, "single_push");
    check("single.count", 32'(rif.count), 1);
    step(1'b1, 3'b000, 1'b1, 1'b0, "single_pop");
    check("single.rd_valid", 32'(rif.rd_valid), 1);
    check("single.rd_data", 32'(rif.rd_data), 32'h42);
    step(1'b1, 3'b000, 1'b0, 1'b0, "single_hold");
    check("single.hold_valid", 32'(rif.rd_valid), 0);
    check("single.hold_data", 32'(rif.rd_data), 32'h42);

    // Simultaneous edges, held, then a further line rising.
    repeat (5) step(1'b1, 3'b101, 1'b0, 1'b0, "held");
    check("held.count", 32'(rif.count), 1);
    step(1'b1, 3'b111, 1'b0, 1'b0, "add_line");
    step(1'b1, 3'b111, 1'b1, 1'b0, "held_pop1");
    check("held.edges1", 32'(rif.rd_data[EW-1:TSW]), 32'b101);
    step(1'b1, 3'b000, 1'b1, 1'b0, "held_pop2");
    check("held.edges2", 32'(rif.rd_data[EW-1:TSW]), 32'b010);

    // Nine events into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 3'(1 << (i % 3)), 1'b0, 1'b0, "fill");
      step(1'b1, 3'b000, 1'b0, 1'b0, "fill_gap");
    end
    check("ovf.full", 32'(rif.full), 1);
    check("ovf.count", 32'(rif.count), 8);
    check("ovf.overflow", 32'(rif.overflow), 1);
    repeat (8) step(1'b1, 3'b000, 1'b1, 1'b0, "drain");
    check("drain.empty", 32'(rif.empty), 1);
    step(1'b1, 3'b000, 1'b1, 1'b0, "empty_req");
    check("empty_req.rd_valid", 32'(rif.rd_valid), 0);
    step(1'b1, 3'b000, 1'b0, 1'b1, "clear_ovf");
    check("clear_ovf.overflow", 32'(rif.overflow), 0);

    // Full with push and pop in the same cycle.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'b001, 1'b0, 1'b0, "refill");
      step(1'b1, 3'b000, 1'b0, 1'b0, "refill_gap");
    end
    step(1'b1, 3'b100, 1'b1, 1'b0, "full_pushpop");
    check("full_pushpop.count", 32'(rif.count), 8);
    check("full_pushpop.overflow", 32'(rif.overflow), 0);
    check("full_pushpop.rd_valid", 32'(rif.rd_valid), 1);
    repeat (8) step(1'b1, 3'b000, 1'b1, 1'b0, "drain2");

    // Long randomized run; covers timestamp wraps and overflow races.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) != 0, NS'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, "rand");
    end

    // Disabled: edges ignored, timestamp frozen.
    saved = exp_q.size();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, NS'($urandom_range(0, 7)), 1'b0, 1'b0, "disabled");
    end
    check("disabled.count", 32'(rif.count), saved);
    step(1'b1, 3'b000, 1'b0, 1'b0, "reenable");

    // Asynchronous reset with five words stored.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      step(1'b1, 3'b000, 1'b1, 1'b0, "pre_rst_drain");
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'b011, 1'b0, 1'b0, "pre_rst_push");
      step(1'b1, 3'b000, 1'b0, 1'b0, "pre_rst_gap");
    end
    check("pre_rst.count", 32'(rif.count), 5);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst.count", 32'(rif.count), 0);
    check("async_rst.empty", 32'(rif.empty), 1);
    check("async_rst.overflow", 32'(rif.overflow), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable             = 1'b0;
    spikes             = '0;
    rif.rd_req         = 1'b0;
    rif.clear_overflow = 1'b0;
    reset              = 1'b1;
    model_reset();
    step(1'b1, 3'b000, 1'b1, 1'b0, "rst2_release");
    for (int i = 0; i < 100; i++) begin
      step(1'b1, NS'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           1'b0, "rand2");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
